// File: rtl/sobel_frame_ctrl.sv
// Output frame sequencer: drops fill-up results, adds borders, flags frame end.
// Border insertion is compiled in only when SOBEL_FRAME_BORDER_EN is defined.
module sobel_frame_ctrl #(
  parameter int WIDTH        = 720,
  parameter int HEIGHT       = 540,
  parameter int DWIDTH       = 8,
  parameter int CWIDTH       = 16,
  parameter int BORDER_VALUE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DWIDTH-1:0] in_dout,
  input  logic              in_empty,
  output logic              in_rd_en,
  output logic [DWIDTH-1:0] out_din,
  input  logic              out_full,
  output logic              out_wr_en,
  output logic              busy,
  output logic              done,
  output logic [CWIDTH-1:0] row
);

`ifdef SOBEL_FRAME_BORDER_EN
  typedef enum logic [2:0] {
    S_IDLE, S_TOP, S_DISCARD, S_HEAD,
    S_BODY, S_TAIL, S_BOTTOM, S_DONE
  } state_t;
  localparam logic [CWIDTH-1:0] ROW_LAST = CWIDTH'(HEIGHT - 2);
  localparam logic [DWIDTH-1:0] BORDER = DWIDTH'(BORDER_VALUE);
`else
  typedef enum logic [1:0] {
    S_IDLE, S_DISCARD, S_BODY, S_DONE
  } state_t;
  localparam logic [CWIDTH-1:0] ROW_LAST = CWIDTH'(HEIGHT - 3);
  logic unused_border;
  assign unused_border = ^DWIDTH'(BORDER_VALUE);
`endif

  state_t            state;
  logic [CWIDTH-1:0] col;
  logic [CWIDTH-1:0] col_max;
  logic              fire;

  always_comb begin
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    out_din   = '0;
    col_max   = '0;
    unique case (state)
      S_DISCARD: begin
        in_rd_en = !in_empty;
        col_max  = CWIDTH'(1);
      end
      S_BODY: begin
        in_rd_en  = !in_empty && !out_full;
        out_wr_en = !in_empty && !out_full;
        out_din   = in_dout;
        col_max   = CWIDTH'(WIDTH - 3);
      end
`ifdef SOBEL_FRAME_BORDER_EN
      S_TOP, S_BOTTOM: begin
        out_wr_en = !out_full;
        out_din   = BORDER;
        col_max   = CWIDTH'(WIDTH - 1);
      end
      S_HEAD, S_TAIL: begin
        out_wr_en = !out_full;
        out_din   = BORDER;
      end
`endif
      default: ;
    endcase
    fire = in_rd_en || out_wr_en;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      col   <= '0;
      row   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          busy <= 1'b1;
          col  <= '0;
          row  <= '0;
`ifdef SOBEL_FRAME_BORDER_EN
          state <= S_TOP;
`else
          state <= S_DISCARD;
`endif
        end
        S_DONE: state <= S_IDLE;
        default: if (fire) begin
          if (col != col_max) begin
            col <= col + 1'b1;
          end else begin
            col <= '0;
            case (state)
`ifdef SOBEL_FRAME_BORDER_EN
              S_TOP: begin
                row   <= CWIDTH'(1);
                state <= S_DISCARD;
              end
              S_DISCARD: state <= S_HEAD;
              S_HEAD:    state <= S_BODY;
              S_BODY:    state <= S_TAIL;
              S_TAIL: begin
                row   <= row + 1'b1;
                state <= (row != ROW_LAST) ? S_DISCARD : S_BOTTOM;
              end
              S_BOTTOM: begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
`else
              S_DISCARD: state <= S_BODY;
              S_BODY: if (row != ROW_LAST) begin
                row   <= row + 1'b1;
                state <= S_DISCARD;
              end else begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl at WIDTH=5, HEIGHT=4.
// Expectations follow SOBEL_FRAME_BORDER_EN in the same way as the design.
module tb_sobel_frame_ctrl;
  localparam int W = 5;
  localparam int H = 4;
  localparam int NONE = -100;

`ifdef SOBEL_FRAME_BORDER_EN
  localparam int T_FRAME = 25;
  localparam int FULL_AT = 10;
  localparam int E1 = 6;
  localparam int E2 = 22;
  localparam int RST_AT = 17;
  logic [7:0] exp_q[$] = '{
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h12, 8'h13, 8'h14, 8'h00,
    8'h00, 8'h17, 8'h18, 8'h19, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
  localparam int T_FRAME = 11;
  localparam int FULL_AT = 4;
  localparam int E1 = 1;
  localparam int E2 = 14;
  localparam int RST_AT = 9;
  logic [7:0] exp_q[$] = '{
    8'h12, 8'h13, 8'h14, 8'h17, 8'h18, 8'h19};
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_dout = 8'h00;
  logic        in_empty = 1'b1;
  logic        in_rd_en;
  logic [7:0]  out_din;
  logic        out_full = 1'b0;
  logic        out_wr_en;
  logic        busy;
  logic        done;
  logic [15:0] row;

  int tests = 0;
  int fails = 0;
  int pops;
  int bad;
  logic [7:0] src[$];
  logic [7:0] got[$];

  sobel_frame_ctrl #(
    .WIDTH(W), .HEIGHT(H), .DWIDTH(8),
    .CWIDTH(16), .BORDER_VALUE(0)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en),
    .busy(busy), .done(done), .row(row)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs mid-cycle, then sample the combinational handshake.
  task automatic tick(input bit st, input bit full, input bit starve);
    logic [7:0] tmp;
    @(negedge clock);
    start    = st;
    out_full = full;
    in_empty = starve || (src.size() == 0);
    in_dout  = (src.size() != 0) ? src[0] : 8'h00;
    #1;
    if (in_rd_en && in_empty) bad++;
    if (out_wr_en && out_full) bad++;
    if (in_rd_en && out_full) bad++;
    if (in_rd_en) begin
      pops++;
      tmp = src.pop_front();
    end
    if (out_wr_en) got.push_back(out_din);
  endtask

  task automatic load_src();
    src.delete();
    got.delete();
    pops = 0;
    bad  = 0;
    for (int i = 0; i < 10; i++) src.push_back(8'(8'h10 + i));
  endtask

  task automatic check_out(input string tag);
    int nmis;
    nmis = 0;
    foreach (exp_q[i])
      if (i >= got.size() || got[i] !== exp_q[i]) nmis++;
    check({tag, "_writes"}, got.size(), exp_q.size());
    check({tag, "_seq_mis"}, nmis, 0);
    check({tag, "_pops"}, pops, 10);
    check({tag, "_handshake"}, bad, 0);
  endtask

  task automatic run_frame(input string tag, input int full_at,
                           input int e1, input int e2, input int s2,
                           input int s3, input int exp_done);
    int done_at;
    logic b1, bd;
    logic [15:0] rd;
    b1 = 1'b0;
    bd = 1'b1;
    rd = '1;
    load_src();
    tick(1'b1, 1'b0, 1'b0);
    check({tag, "_done_idle"}, done, 0);
    done_at = -1;
    for (int k = 1; k < 300 && done_at < 0; k++) begin
      tick(k == s2 || k == s3,
           k >= full_at && k < full_at + 3,
           (k >= e1 && k < e1 + 5) || (k >= e2 && k < e2 + 5));
      if (k == 1) b1 = busy;
      if (done) begin
        done_at = k;
        bd = busy;
        rd = row;
      end
    end
    check({tag, "_done_at"}, done_at, exp_done);
    check({tag, "_busy_start"}, b1, 1);
    check({tag, "_busy_done"}, bd, 0);
`ifdef SOBEL_FRAME_BORDER_EN
    check({tag, "_row_done"}, rd, H - 1);
`endif
    check_out(tag);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    #1;
    check("reset_outs", {in_rd_en, out_wr_en, out_din, busy, done, row}, 0);
    @(negedge clock);
    reset = 1'b1;

    run_frame("basic", NONE, NONE, NONE, NONE, NONE, T_FRAME);
    run_frame("backpressure", FULL_AT, NONE, NONE, NONE, NONE, T_FRAME + 3);
    run_frame("starve", NONE, E1, E2, NONE, NONE, T_FRAME + 10);
    run_frame("start_ign", NONE, NONE, NONE, 3, T_FRAME, T_FRAME);
    run_frame("after_done", NONE, NONE, NONE, NONE, NONE, T_FRAME);

    load_src();
    tick(1'b1, 1'b0, 1'b0);
    for (int k = 1; k < RST_AT; k++) tick(1'b0, 1'b0, 1'b0);
`ifdef SOBEL_FRAME_BORDER_EN
    check("midframe_row", row, 2);
`endif
    check("midframe_busy", busy, 1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_mid_outs",
          {in_rd_en, out_wr_en, out_din, busy, done, row}, 0);
    @(negedge clock);
    reset = 1'b1;
    run_frame("post_reset", NONE, NONE, NONE, NONE, NONE, T_FRAME);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
